// File: rtl/sd_block_engine_pkg.sv
// Shared constants for the SD block engine: FSM state encodings, per-byte
// transfer phases, error codes and the card token values.
package sd_block_engine_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_RD_TOKEN = 4'd1;
  localparam logic [3:0] ST_RD_DATA  = 4'd2;
  localparam logic [3:0] ST_RD_CRC   = 4'd3;
  localparam logic [3:0] ST_WR_TOKEN = 4'd4;
  localparam logic [3:0] ST_WR_FETCH = 4'd5;
  localparam logic [3:0] ST_WR_DATA  = 4'd6;
  localparam logic [3:0] ST_WR_CRC   = 4'd7;
  localparam logic [3:0] ST_WR_RESP  = 4'd8;
  localparam logic [3:0] ST_WR_BUSY  = 4'd9;
  localparam logic [3:0] ST_FINISH   = 4'd10;

  // PH_CRC is the idle gap in which the shifter CRC is cleared.
  typedef enum logic [1:0] {
    PH_ISSUE = 2'd0,
    PH_SKIP  = 2'd1,
    PH_WAIT  = 2'd2,
    PH_CRC   = 2'd3
  } phase_t;

  localparam logic [2:0] ERR_OK            = 3'd0;
  localparam logic [2:0] ERR_TOKEN_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_TOKEN         = 3'd2;
  localparam logic [2:0] ERR_CRC           = 3'd3;
  localparam logic [2:0] ERR_WR_REJECT     = 3'd4;
  localparam logic [2:0] ERR_BUSY_TIMEOUT  = 3'd5;

  localparam logic [7:0] TOKEN_START   = 8'hFE;
  localparam logic [4:0] RESP_ACCEPTED = 5'h05;

  function automatic logic is_error_token(input logic [7:0] b);
    return b[7:4] == 4'h0;
  endfunction

  function automatic logic is_resp_accepted(input logic [7:0] b);
    return b[4:0] == RESP_ACCEPTED;
  endfunction

endpackage

// File: rtl/sd_block_engine.sv
// SD block read/write sequencer: drives a byte shifter through token, data,
// CRC, write-response and busy phases and reports a per-transfer status.
module sd_block_engine
  import sd_block_engine_pkg::*;
#(
  parameter int BLOCK_LEN     = 512,
  parameter int TOKEN_TIMEOUT = 4096,
  parameter int BUSY_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_read,
  input  logic        cmd_write,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        sh_start_write,
  output logic        sh_start_read,
  output logic        sh_crc_reset,
  output logic        sh_crc_source,
  output logic [7:0]  sh_data_in,
  input  logic [7:0]  sh_data_out,
  input  logic        sh_busy,
  input  logic [15:0] sh_crc_out,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err
);

  localparam logic [10:0] LAST_BYTE   = 11'(BLOCK_LEN);
  localparam logic [15:0] TOKEN_LIMIT = 16'(TOKEN_TIMEOUT);
  localparam logic [15:0] BUSY_LIMIT  = 16'(BUSY_TIMEOUT);

  logic [3:0]  state_reg, state_next;
  phase_t      phase_reg, phase_next;
  logic [10:0] byte_cnt_reg, byte_cnt_next;
  logic [15:0] tmo_cnt_reg, tmo_cnt_next;
  logic [15:0] crc_exp_reg, crc_exp_next;
  logic [7:0]  data_reg, data_next;
  logic [2:0]  err_reg, err_next;
  logic        crc_source_reg, crc_source_next;
  logic        crc_bad_reg, crc_bad_next;

  logic        rd_state;
  logic        wr_state;
  logic        xfer_done;
  logic [10:0] byte_cnt_inc;
  logic [15:0] tmo_cnt_inc;

  always_comb begin
    rd_state  = state_reg inside {ST_RD_TOKEN, ST_RD_DATA, ST_RD_CRC, ST_WR_RESP, ST_WR_BUSY};
    wr_state  = state_reg inside {ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC};
    xfer_done = (rd_state || wr_state) && (phase_reg == PH_WAIT) && !sh_busy;
    byte_cnt_inc = (byte_cnt_reg == 11'h7FF) ? byte_cnt_reg : byte_cnt_reg + 11'd1;
    tmo_cnt_inc  = (tmo_cnt_reg == 16'hFFFF) ? tmo_cnt_reg : tmo_cnt_reg + 16'd1;
  end

  // Status and stream strobes decode registered state, so reset drives them low directly.
  always_comb begin
    sh_start_read  = rd_state && (phase_reg == PH_ISSUE);
    sh_start_write = wr_state && (phase_reg == PH_ISSUE);
    sh_crc_reset   = (phase_reg == PH_CRC) && !sh_busy &&
                     ((state_reg == ST_RD_DATA) || (state_reg == ST_WR_TOKEN));
    sh_crc_source  = crc_source_reg;
    rd_valid       = (state_reg == ST_RD_DATA) && xfer_done;
    rd_data        = rd_valid ? sh_data_out : 8'h00;
    wr_ready       = (state_reg == ST_WR_FETCH);
    busy           = (state_reg != ST_IDLE);
    done           = (state_reg == ST_FINISH);
    err            = err_reg;
    case (state_reg)
      ST_WR_TOKEN: sh_data_in = TOKEN_START;
      ST_WR_DATA:  sh_data_in = data_reg;
      ST_WR_CRC:   sh_data_in = (byte_cnt_reg == 11'd0) ? crc_exp_reg[15:8] : crc_exp_reg[7:0];
      default:     sh_data_in = 8'h00;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    byte_cnt_next   = byte_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    crc_exp_next    = crc_exp_reg;
    data_next       = data_reg;
    err_next        = err_reg;
    crc_source_next = crc_source_reg;
    crc_bad_next    = crc_bad_reg;

    // Generic byte-transfer sequencing; the state case below overrides it.
    if ((rd_state || wr_state) && (phase_reg == PH_ISSUE)) phase_next = PH_SKIP;
    if (phase_reg == PH_SKIP) phase_next = PH_WAIT;
    if (xfer_done) phase_next = PH_ISSUE;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_read ^ cmd_write) begin
          err_next      = ERR_OK;
          byte_cnt_next = 11'd0;
          tmo_cnt_next  = 16'd0;
          crc_bad_next  = 1'b0;
          phase_next    = PH_ISSUE;
          state_next    = cmd_read ? ST_RD_TOKEN : ST_WR_TOKEN;
        end
      end
      ST_RD_TOKEN: begin
        if (xfer_done) begin
          if (sh_data_out == TOKEN_START) begin
            state_next      = ST_RD_DATA;
            phase_next      = PH_CRC;
            crc_source_next = 1'b1;
          end else if (is_error_token(sh_data_out)) begin
            err_next   = ERR_TOKEN;
            state_next = ST_FINISH;
          end else begin
            tmo_cnt_next = tmo_cnt_inc;
            if (tmo_cnt_inc >= TOKEN_LIMIT) begin
              err_next   = ERR_TOKEN_TIMEOUT;
              state_next = ST_FINISH;
            end
          end
        end
      end
      ST_RD_DATA: begin
        if (phase_reg == PH_CRC) begin
          if (!sh_busy) begin
            phase_next    = PH_ISSUE;
            byte_cnt_next = 11'd0;
          end
        end else if (xfer_done) begin
          byte_cnt_next = byte_cnt_inc;
          if (byte_cnt_inc == LAST_BYTE) begin
            crc_exp_next  = sh_crc_out;
            byte_cnt_next = 11'd0;
            state_next    = ST_RD_CRC;
          end
        end
      end
      ST_RD_CRC: begin
        if (xfer_done) begin
          if (byte_cnt_reg == 11'd0) begin
            byte_cnt_next = 11'd1;
            crc_bad_next  = (sh_data_out != crc_exp_reg[15:8]);
          end else begin
            err_next   = (crc_bad_reg || (sh_data_out != crc_exp_reg[7:0])) ? ERR_CRC : ERR_OK;
            state_next = ST_FINISH;
          end
        end
      end
      ST_WR_TOKEN: begin
        if (phase_reg == PH_CRC) begin
          if (!sh_busy) begin
            state_next    = ST_WR_FETCH;
            phase_next    = PH_ISSUE;
            byte_cnt_next = 11'd0;
          end
        end else if (xfer_done) begin
          phase_next      = PH_CRC;
          crc_source_next = 1'b0;
        end
      end
      ST_WR_FETCH: begin
        if (wr_valid) begin
          data_next  = wr_data;
          state_next = ST_WR_DATA;
          phase_next = PH_ISSUE;
        end
      end
      ST_WR_DATA: begin
        if (xfer_done) begin
          byte_cnt_next = byte_cnt_inc;
          if (byte_cnt_inc == LAST_BYTE) begin
            // Latched so the CRC bytes sent are not disturbed by the shifter updating its CRC.
            crc_exp_next  = sh_crc_out;
            byte_cnt_next = 11'd0;
            state_next    = ST_WR_CRC;
          end else begin
            state_next = ST_WR_FETCH;
          end
        end
      end
      ST_WR_CRC: begin
        if (xfer_done) begin
          if (byte_cnt_reg == 11'd0) begin
            byte_cnt_next = 11'd1;
          end else begin
            byte_cnt_next = 11'd0;
            state_next    = ST_WR_RESP;
          end
        end
      end
      ST_WR_RESP: begin
        if (xfer_done) begin
          if (is_resp_accepted(sh_data_out)) begin
            state_next   = ST_WR_BUSY;
            tmo_cnt_next = 16'd0;
          end else begin
            err_next   = ERR_WR_REJECT;
            state_next = ST_FINISH;
          end
        end
      end
      ST_WR_BUSY: begin
        if (xfer_done) begin
          if (sh_data_out != 8'h00) begin
            err_next   = ERR_OK;
            state_next = ST_FINISH;
          end else begin
            tmo_cnt_next = tmo_cnt_inc;
            if (tmo_cnt_inc >= BUSY_LIMIT) begin
              err_next   = ERR_BUSY_TIMEOUT;
              state_next = ST_FINISH;
            end
          end
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
        phase_next = PH_ISSUE;
      end
      default: begin
        state_next = ST_IDLE;
        phase_next = PH_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= PH_ISSUE;
      byte_cnt_reg   <= 11'd0;
      tmo_cnt_reg    <= 16'd0;
      crc_exp_reg    <= 16'd0;
      data_reg       <= 8'd0;
      err_reg        <= ERR_OK;
      crc_source_reg <= 1'b0;
      crc_bad_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      byte_cnt_reg   <= byte_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      crc_exp_reg    <= crc_exp_next;
      data_reg       <= data_next;
      err_reg        <= err_next;
      crc_source_reg <= crc_source_next;
      crc_bad_reg    <= crc_bad_next;
    end
  end

endmodule

// File: tb/tb_sd_block_engine.sv
// Bench for sd_block_engine: a behavioural byte shifter with CRC16 feeds a
// scripted card stream; table-driven transfers plus reset/command corner cases.
module tb_sd_block_engine;

  localparam int BLEN = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_read, cmd_write;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        sh_start_write, sh_start_read, sh_crc_reset, sh_crc_source;
  logic [7:0]  sh_data_in, sh_data_out;
  logic        sh_busy;
  logic [15:0] sh_crc_out;
  logic        busy, done;
  logic [2:0]  err;

  sd_block_engine #(.BLOCK_LEN(BLEN), .TOKEN_TIMEOUT(16), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cmd_read(cmd_read), .cmd_write(cmd_write),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .sh_start_write(sh_start_write), .sh_start_read(sh_start_read),
    .sh_crc_reset(sh_crc_reset), .sh_crc_source(sh_crc_source),
    .sh_data_in(sh_data_in), .sh_data_out(sh_data_out), .sh_busy(sh_busy),
    .sh_crc_out(sh_crc_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[15] ^ d[7-k]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else                r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // ---------------- card / shifter model ----------------
  logic [7:0] card_mem [0:1023];
  int         card_len = 0;
  int         card_start = 0;
  logic [7:0] card_fill = 8'hFF;
  logic [7:0] card_byte;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         both_starts = 0;
  logic [7:0] mosi_mem [0:4095];
  logic       m_busy, m_is_read;
  logic [1:0] m_cnt;
  logic [7:0] m_dout, m_mosi;
  logic [15:0] m_crc;

  always_comb begin
    card_byte = card_fill;
    if ((rd_cnt - card_start) < card_len) card_byte = card_mem[rd_cnt - card_start];
  end

  assign sh_busy     = m_busy;
  assign sh_data_out = m_dout;
  assign sh_crc_out  = m_crc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 2'd0; m_crc <= 16'h0; m_dout <= 8'h0;
      m_is_read <= 1'b0; m_mosi <= 8'h0;
    end else begin
      if (sh_crc_reset) m_crc <= 16'h0;
      if (sh_start_read && sh_start_write) both_starts <= both_starts + 1;
      if (sh_start_read || sh_start_write) begin
        m_busy <= 1'b1; m_cnt <= 2'd2; m_is_read <= sh_start_read; m_mosi <= sh_data_in;
      end else if (m_busy) begin
        if (m_cnt == 2'd1) begin
          m_busy <= 1'b0;
          if (m_is_read) begin
            m_dout <= card_byte;
            rd_cnt <= rd_cnt + 1;
          end else begin
            m_dout <= 8'hFF;
            mosi_mem[wr_cnt] <= m_mosi;
            wr_cnt <= wr_cnt + 1;
          end
          m_crc <= crc16_byte(m_crc, sh_crc_source ? (m_is_read ? card_byte : 8'hFF) : m_mosi);
        end else begin
          m_cnt <= m_cnt - 2'd1;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] rx_mem [0:8191];
  int rx_cnt = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (rd_valid) begin rx_mem[rx_cnt] <= rd_data; rx_cnt <= rx_cnt + 1; end
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":busy"}, 32'(busy), 0);
    check({tag, ":done"}, 32'(done), 0);
    check({tag, ":err"}, 32'(err), 0);
    check({tag, ":wr_ready"}, 32'(wr_ready), 0);
    check({tag, ":rd_valid"}, 32'(rd_valid), 0);
    check({tag, ":rd_data"}, 32'(rd_data), 0);
    check({tag, ":sh_start_read"}, 32'(sh_start_read), 0);
    check({tag, ":sh_start_write"}, 32'(sh_start_write), 0);
    check({tag, ":sh_crc_reset"}, 32'(sh_crc_reset), 0);
    check({tag, ":sh_crc_source"}, 32'(sh_crc_source), 0);
    check({tag, ":sh_data_in"}, 32'(sh_data_in), 0);
  endtask

  typedef struct {
    string      name;
    bit         is_write;
    int         pre_ff;
    logic [7:0] token;
    bit         corrupt;
    logic [7:0] resp;
    int         n_busy;
    int         stall_at;
    bit         poke_cmd;
    logic [2:0] exp_err;
    int         exp_rx;
    int         exp_polls;
    int         exp_mosi;
  } vec_t;

  vec_t vecs[8];

  task automatic push_card(input logic [7:0] b);
    card_mem[card_len] = b;
    card_len++;
  endtask

  task automatic run_vec(input vec_t v);
    int base_rd, base_wr, base_rx, base_done, sent, stall_left, mism;
    bit got, pend;
    logic [15:0] crc;
    logic [7:0] exp_b;

    card_len = 0;
    card_fill = 8'hFF;
    crc = 16'h0;
    if (!v.is_write) begin
      for (int i = 0; i < v.pre_ff; i++) push_card(8'hFF);
      push_card(v.token);
      if (v.token == 8'hFE) begin
        for (int i = 0; i < BLEN; i++) begin
          push_card(i[7:0]);
          crc = crc16_byte(crc, i[7:0]);
        end
        push_card(crc[15:8]);
        push_card(crc[7:0] ^ {7'd0, v.corrupt});
      end
    end else begin
      push_card(v.resp);
      for (int i = 0; i < v.n_busy; i++) push_card(8'h00);
      for (int i = 0; i < BLEN; i++) crc = crc16_byte(crc, 8'hA5);
    end

    @(negedge clk);
    base_rd = rd_cnt; base_wr = wr_cnt; base_rx = rx_cnt; base_done = done_cnt;
    card_start = rd_cnt;
    if (v.is_write) cmd_write = 1'b1; else cmd_read = 1'b1;
    @(negedge clk);
    cmd_read = 1'b0; cmd_write = 1'b0;

    got = 0; sent = 0; pend = 0; stall_left = 0;
    for (int c = 0; c < 40000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
      if (v.poke_cmd) begin
        cmd_write = (c == 200);
      end
      if (v.is_write) begin
        if (pend) begin
          pend = 0;
          if (v.stall_at > 0 && sent == v.stall_at) stall_left = 10;
        end
        if (stall_left > 0) begin
          wr_valid = 1'b0;
          stall_left--;
        end else begin
          wr_valid = (sent < BLEN);
        end
        wr_data = 8'hA5;
        if (wr_valid && wr_ready) begin sent++; pend = 1; end
      end
    end
    wr_valid = 1'b0;
    cmd_write = 1'b0;

    check({v.name, ":done_seen"}, 32'(got), 1);
    check({v.name, ":err"}, 32'(err), 32'(v.exp_err));
    repeat (3) @(negedge clk);
    check({v.name, ":busy_after"}, 32'(busy), 0);
    check({v.name, ":err_held"}, 32'(err), 32'(v.exp_err));
    check({v.name, ":done_pulses"}, 32'(done_cnt - base_done), 1);
    check({v.name, ":rx_count"}, 32'(rx_cnt - base_rx), 32'(v.exp_rx));
    check({v.name, ":polls"}, 32'(rd_cnt - base_rd), 32'(v.exp_polls));
    check({v.name, ":mosi_count"}, 32'(wr_cnt - base_wr), 32'(v.exp_mosi));
    if (v.exp_rx > 0) begin
      mism = 0;
      for (int i = 0; i < v.exp_rx; i++)
        if (rx_mem[base_rx + i] !== i[7:0]) mism++;
      check({v.name, ":rx_data_mismatches"}, 32'(mism), 0);
    end
    if (v.exp_mosi > 0) begin
      mism = 0;
      for (int i = 0; i < v.exp_mosi; i++) begin
        if (i == 0)             exp_b = 8'hFE;
        else if (i <= BLEN)     exp_b = 8'hA5;
        else if (i == BLEN + 1) exp_b = crc[15:8];
        else                    exp_b = crc[7:0];
        if (mosi_mem[base_wr + i] !== exp_b) mism++;
      end
      check({v.name, ":mosi_mismatches"}, 32'(mism), 0);
    end
    $display("%s: err=%0d rx=%0d polls=%0d mosi=%0d", v.name, err,
             rx_cnt - base_rx, rd_cnt - base_rd, wr_cnt - base_wr);
  endtask

  initial begin
    int base_rx, base_done, base_rd;
    bit reached;

    vecs[0] = '{"read_ok",          0, 3, 8'hFE, 0, 8'h00, 0,  0,   0, 3'd0, 512, 518, 0};
    vecs[1] = '{"read_crc_bad",     0, 3, 8'hFE, 1, 8'h00, 0,  0,   0, 3'd3, 512, 518, 0};
    vecs[2] = '{"read_tok_timeout", 0, 0, 8'hFF, 0, 8'h00, 0,  0,   0, 3'd1, 0,   16,  0};
    vecs[3] = '{"read_err_token",   0, 2, 8'h08, 0, 8'h00, 0,  0,   0, 3'd2, 0,   3,   0};
    vecs[4] = '{"write_ok",         1, 0, 8'h00, 0, 8'hE5, 5,  256, 0, 3'd0, 0,   7,   515};
    vecs[5] = '{"write_reject",     1, 0, 8'h00, 0, 8'h0B, 0,  0,   0, 3'd4, 0,   1,   515};
    vecs[6] = '{"write_busy_tmo",   1, 0, 8'h00, 0, 8'h05, 20, 0,   0, 3'd5, 0,   9,   515};
    vecs[7] = '{"read_cmd_ignored", 0, 3, 8'hFE, 0, 8'h00, 0,  0,   1, 3'd0, 512, 518, 0};

    rst = 1'b1; cmd_read = 1'b0; cmd_write = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both commands together must be ignored.
    base_done = done_cnt; base_rd = rd_cnt;
    cmd_read = 1'b1; cmd_write = 1'b1;
    @(negedge clk);
    cmd_read = 1'b0; cmd_write = 1'b0;
    repeat (10) @(negedge clk);
    check("both_cmds:busy", 32'(busy), 0);
    check("both_cmds:polls", 32'(rd_cnt - base_rd), 0);
    check("both_cmds:done", 32'(done_cnt - base_done), 0);
    $display("both_cmds: busy=%0d", busy);

    // Reset in the middle of data byte 100 of a read.
    card_len = 0;
    push_card(8'hFE);
    for (int i = 0; i < BLEN; i++) push_card(i[7:0]);
    @(negedge clk);
    card_start = rd_cnt; base_rx = rx_cnt; base_done = done_cnt;
    cmd_read = 1'b1;
    @(negedge clk);
    cmd_read = 1'b0;
    reached = 0;
    for (int c = 0; c < 20000 && !reached; c++) begin
      @(negedge clk);
      if (rx_cnt - base_rx >= 100) reached = 1;
    end
    check("rst_mid:reached_byte100", 32'(reached), 1);
    check("rst_mid:busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid:no_done", 32'(done_cnt - base_done), 0);
    check("rst_mid:idle", 32'(busy), 0);
    $display("rst_mid: rx_before_reset=%0d", rx_cnt - base_rx);

    run_vec(vecs[0]);

    check("never_both_starts", 32'(both_starts), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
